// File: rtl/sine_dds_pkg.sv
// sine_dds_pkg
// Shared types and sizing for the multi-channel sine DDS scheduler.
//   NUM_CH   : default channel count; the tag channel field is sized from it
//   CH_W     : channel index width, never below 1
//   state_t  : scheduler state (IDLE / RUN / DRAIN)
//   tag_t    : lookup tag travelling beside the sine lookup pipeline
package sine_dds_pkg;

  localparam int NUM_CH     = 4;
  localparam int ACC_W      = 24;
  localparam int PHASE_W    = 10;
  localparam int AMP_W      = 8;
  localparam int ROM_LAT    = 1;
  localparam int FIFO_DEPTH = 4;

  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } tag_t;

endpackage

// File: rtl/sine_dds_fifo.sv
// sine_dds_fifo
// Small synchronous FIFO holding tagged samples until the consumer takes them.
//   clk, reset_n : clock, synchronous active-low reset (clears storage too)
//   push, din    : write one entry
//   pop          : remove the head (ignored when empty)
//   dout         : current head entry
//   count, empty : occupancy
module sine_dds_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop_ok;

  assign pop_ok = pop && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // push and pop together leave the occupancy unchanged
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/sine_dds_sequencer.sv
// sine_dds_sequencer
// Time-shares one pipelined sine lookup among NUM_CH tone channels. Each
// channel owns a phase accumulator and a frequency control word; lookups are
// issued round-robin, tagged through the lookup latency, and the returned
// samples are queued in an output FIFO with valid/ready handshake.
//   clk, reset_n        : clock, synchronous active-low reset
//   enable              : permit new lookups
//   cfg_we/ch/fcw/clr   : per-channel FCW write, optional accumulator clear
//   rom_phase / rom_y   : registered phase to the lookup / sample back
//   smp_valid/ready/ch/data : tagged sample stream
//   busy                : scheduler not idle
module sine_dds_sequencer
  import sine_dds_pkg::*;
#(
  parameter int NUM_CH     = sine_dds_pkg::NUM_CH,
  parameter int ACC_W      = sine_dds_pkg::ACC_W,
  parameter int PHASE_W    = sine_dds_pkg::PHASE_W,
  parameter int AMP_W      = sine_dds_pkg::AMP_W,
  parameter int ROM_LAT    = sine_dds_pkg::ROM_LAT,
  parameter int FIFO_DEPTH = sine_dds_pkg::FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [ACC_W-1:0]   cfg_fcw,
  input  logic               cfg_clr,
  output logic [PHASE_W-1:0] rom_phase,
  input  logic [AMP_W-1:0]   rom_y,
  output logic               smp_valid,
  input  logic               smp_ready,
  output logic [CH_W-1:0]    smp_ch,
  output logic [AMP_W-1:0]   smp_data,
  output logic               busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ACC_W-1:0]      acc_reg [NUM_CH];
  logic [ACC_W-1:0]      fcw_reg [NUM_CH];
  logic [CH_W-1:0]       ptr_reg;
  tag_t                  tag_reg [ROM_LAT+1];
  tag_t                  tag_out;
  logic [CNT_W-1:0]      in_flight_reg;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  issue;
  logic                  capture;
  logic [NUM_CH-1:0]     cfg_hit;
  logic [NUM_CH-1:0]     issue_hit;
  logic [CH_W+AMP_W-1:0] fifo_dout;
  state_t                state_reg;

  // Credit: every issued lookup already owns a FIFO slot, so the FIFO can
  // never overflow no matter how long the consumer stalls.
  assign issue   = enable && (({1'b0, fifo_count} + {1'b0, in_flight_reg}) < DEPTH_L);
  assign tag_out = tag_reg[ROM_LAT];
  assign capture = tag_out.valid;

  // Per-channel decode; out-of-range cfg_ch values match no channel.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign cfg_hit[gi]   = cfg_we && (cfg_ch == CH_W'(gi));
      assign issue_hit[gi] = issue && (ptr_reg == CH_W'(gi));
    end
  endgenerate

  // Accumulators and FCWs. A same-edge issue adds the old FCW; a clear wins
  // over that edge's accumulate.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_reg[c] <= '0;
        fcw_reg[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_hit[c]) begin
          fcw_reg[c] <= cfg_fcw;
        end
        if (cfg_hit[c] && cfg_clr) begin
          acc_reg[c] <= '0;
        end else if (issue_hit[c]) begin
          acc_reg[c] <= acc_reg[c] + fcw_reg[c];
        end
      end
    end
  end

  // Issue side: phase register, round-robin pointer, tag pipeline and the
  // count of lookups not yet landed in the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_reg       <= '0;
      rom_phase     <= '0;
      in_flight_reg <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_reg[i] <= '0;
      end
    end else begin
      if (issue) begin
        rom_phase <= acc_reg[ptr_reg][ACC_W-1 -: PHASE_W];
        ptr_reg   <= (ptr_reg == CH_W'(NUM_CH - 1)) ? '0 : ptr_reg + 1'b1;
      end
      // tags ride one stage longer than the lookup because rom_phase itself
      // is a register in front of it
      tag_reg[0] <= '{valid: issue, ch: ptr_reg};
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
      case ({issue, capture})
        2'b10:   in_flight_reg <= in_flight_reg + 1'b1;
        2'b01:   in_flight_reg <= in_flight_reg - 1'b1;
        default: in_flight_reg <= in_flight_reg;
      endcase
    end
  end

  sine_dds_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CH_W + AMP_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (capture),
    .din     ({tag_out.ch, rom_y}),
    .pop     (smp_valid && smp_ready),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign smp_valid = !fifo_empty;
  assign smp_ch    = fifo_dout[CH_W+AMP_W-1:AMP_W];
  assign smp_data  = fifo_dout[AMP_W-1:0];

  // DRAIN only tracks outstanding work after enable falls; issue itself is
  // governed by enable and credit alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) state_reg <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state_reg <= ((in_flight_reg != '0) || !fifo_empty) ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (enable) begin
            state_reg <= RUN;
          end else if ((in_flight_reg == '0) && fifo_empty) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_sine_dds_sequencer.sv
// tb_sine_dds_sequencer
// Drives the DDS scheduler with directed and random stimulus and compares it
// each cycle against a queue-based reference of outstanding samples.
module tb_sine_dds_sequencer;
  import sine_dds_pkg::*;

  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int RLAT  = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [23:0]       cfg_fcw;
  logic              cfg_clr;
  logic [9:0]        rom_phase;
  logic [7:0]        rom_y;
  logic              smp_valid;
  logic              smp_ready;
  logic [CH_W-1:0]   smp_ch;
  logic [7:0]        smp_data;
  logic              busy;

  always #5 clk = ~clk;

  sine_dds_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_fcw   (cfg_fcw),
    .cfg_clr   (cfg_clr),
    .rom_phase (rom_phase),
    .rom_y     (rom_y),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .smp_ch    (smp_ch),
    .smp_data  (smp_data),
    .busy      (busy)
  );

  // Offset-binary full sine: 128 + round(127*sin(2*pi*p/1024)).
  function automatic logic [7:0] sine_val(input logic [9:0] p);
    real r;
    r = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 1024.0);
    return 8'($rtoi($floor(r + 0.5)));
  endfunction

  // Team sine lookup: one register stage.
  always @(posedge clk) rom_y <= sine_val(rom_phase);

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: every issued lookup is one outstanding sample (in flight or
  // buffered); credit is simply "fewer than DEPTH outstanding".
  typedef struct {
    int ch;
    int data;
    int t;
  } exp_t;

  exp_t        q[$];
  logic [23:0] m_acc [NCH];
  logic [23:0] m_fcw [NCH];
  int          m_ptr;
  int          m_state;  // 0 idle, 1 run, 2 drain
  logic [9:0]  m_rom_phase;
  int          edge_cnt = 0;
  int          del_ch[$];
  int          del_data[$];

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = '0;
      m_fcw[c] = '0;
    end
    m_ptr       = 0;
    m_state     = 0;
    m_rom_phase = '0;
  endtask

  task automatic cycle();
    bit         exp_valid;
    bit         issue;
    int         outstanding;
    logic [9:0] ph;
    exp_valid = (q.size() > 0) && (edge_cnt - q[0].t >= RLAT + 1);
    check_val("smp_valid", smp_valid, exp_valid);
    check_val("busy", busy, m_state != 0);
    check_val("rom_phase", rom_phase, m_rom_phase);
    if (exp_valid && smp_valid) begin
      check_val("smp_ch", smp_ch, q[0].ch);
      check_val("smp_data", smp_data, q[0].data);
    end
    if (!reset_n) begin
      model_reset();
    end else begin
      outstanding = q.size();
      issue = enable && (outstanding < DEPTH);
      case (m_state)
        0: if (enable) m_state = 1;
        1: if (!enable) m_state = (outstanding != 0) ? 2 : 0;
        default: begin
          if (enable) m_state = 1;
          else if (outstanding == 0) m_state = 0;
        end
      endcase
      if (exp_valid && smp_ready) begin
        $display("smp ch=%0d data=%0d", smp_ch, smp_data);
        del_ch.push_back(int'(smp_ch));
        del_data.push_back(int'(smp_data));
        void'(q.pop_front());
      end
      if (issue) begin
        ph = m_acc[m_ptr][23:14];
        q.push_back('{m_ptr, int'(sine_val(ph)), edge_cnt + 1});
        m_rom_phase  = ph;
        m_acc[m_ptr] = m_acc[m_ptr] + m_fcw[m_ptr];
        m_ptr        = (m_ptr + 1) % NCH;
      end
      if (cfg_we && (int'(cfg_ch) < NCH)) begin
        m_fcw[cfg_ch] = cfg_fcw;
        if (cfg_clr) m_acc[cfg_ch] = '0;
      end
    end
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int mark;
    int n1;
    int out;
    int idx;
    logic [9:0] pre;
    int exp_tbl[5];
    exp_tbl = '{128, 255, 128, 1, 128};

    reset_n = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_fcw = '0; cfg_clr = 1'b0; smp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;

    // reset state
    check_val("rst_rom_phase", rom_phase, 0);
    check_val("rst_smp_valid", smp_valid, 0);
    check_val("rst_smp_ch", smp_ch, 0);
    check_val("rst_smp_data", smp_data, 0);
    check_val("rst_busy", busy, 0);

    // phase stepping on ch1 and first-sample latency
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_fcw = 24'h400000;
    cycle();
    cfg_we = 1'b0;
    enable = 1'b1;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      lat++;
      if (smp_valid) break;
    end
    // counted in edges, the issue edge included
    check_val("latency", lat, 3);
    for (int k = 0; k < 30; k++) begin
      cycle();
      check_val("stream_valid", smp_valid, 1);
    end
    n1 = 0;
    for (int i = 0; i < del_ch.size(); i++) begin
      if (i < 8) check_val("step_order", del_ch[i], i % NCH);
      if (del_ch[i] == 1 && n1 < 5) begin
        check_val("step_ch1", del_data[i], exp_tbl[n1]);
        n1++;
      end else if (del_ch[i] != 1 && i < 8) begin
        check_val("step_const", del_data[i], 128);
      end
    end
    check_val("step_n1", n1, 5);

    // backpressure
    smp_ready = 1'b0;
    for (int k = 0; k < 20; k++) cycle();
    check_val("bp_busy", busy, 1);
    check_val("bp_held", smp_valid, 1);
    mark = del_ch.size();
    smp_ready = 1'b1;
    for (int k = 0; k < 16; k++) cycle();
    for (int i = mark; i < del_ch.size(); i++) begin
      check_val("bp_order", del_ch[i], (del_ch[i-1] + 1) % NCH);
    end

    // config collision on ch1
    for (int k = 0; k < 20; k++) begin
      if (m_ptr == 1 && q.size() < DEPTH && m_acc[1][23:14] != 0) break;
      cycle();
    end
    pre = m_acc[1][23:14];
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_clr = 1'b1; cfg_fcw = 24'h400000;
    cycle();
    cfg_we = 1'b0; cfg_clr = 1'b0;
    check_val("coll_phase", rom_phase, pre);
    for (int k = 0; k < 20; k++) begin
      if (m_ptr == 1 && q.size() < DEPTH) break;
      cycle();
    end
    cycle();
    check_val("coll_next_phase", rom_phase, 0);
    mark = del_ch.size();
    for (int k = 0; k < 6; k++) cycle();
    idx = -1;
    for (int i = mark; i < del_ch.size(); i++) begin
      if (del_ch[i] == 1 && idx < 0) idx = i;
    end
    if (idx >= 0) check_val("coll_next_smp", del_data[idx], 128);
    else check_val("coll_next_seen", 0, 1);

    // drain
    out = q.size();
    mark = del_ch.size();
    enable = 1'b0;
    cycle();
    check_val("drain_busy", busy, out != 0);
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      cycle();
    end
    check_val("drain_idle", busy, 0);
    check_val("drain_cnt", del_ch.size() - mark, out);

    // reset while samples are buffered
    enable = 1'b1; smp_ready = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    enable = 1'b0;
    check_val("mid_rst_valid", smp_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    enable = 1'b1; smp_ready = 1'b1;
    mark = del_ch.size();
    for (int k = 0; k < 20; k++) begin
      cycle();
      check_val("mid_rst_phase", rom_phase, 0);
    end
    for (int i = mark; i < del_ch.size(); i++) begin
      check_val("mid_rst_smp", del_data[i], 128);
    end

    // random traffic
    for (int k = 0; k < 400; k++) begin
      enable    = ($urandom % 8) != 0;
      smp_ready = ($urandom % 4) != 0;
      cfg_we    = ($urandom % 12) == 0;
      cfg_ch    = CH_W'($urandom % NCH);
      cfg_fcw   = 24'($urandom);
      cfg_clr   = ($urandom % 3) == 0;
      cycle();
    end
    cfg_we = 1'b0; cfg_clr = 1'b0; enable = 1'b0; smp_ready = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    check_val("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sine_dds_sequencer.md
Name: sine_dds_sequencer

Overview:
Multi-channel direct digital synthesis (DDS) scheduler that time-shares one quarter-wave sine lookup (10-bit phase in, 8-bit offset-binary sample out, fixed pipeline latency) among NUM_CH independent tone channels. It keeps one phase accumulator and one frequency control word (FCW) per channel. It issues lookups round-robin, tags them through the lookup pipeline, and buffers the results in a small output FIFO with valid/ready backpressure. Credit-based issue guarantees no sample is ever dropped.

Parameters:
NUM_CH, 4, number of tone channels (2..16)
ACC_W, 24, phase accumulator / FCW width
PHASE_W, 10, phase width driven to the lookup (top PHASE_W bits of the accumulator)
AMP_W, 8, sample width returned by the lookup
ROM_LAT, 1, register stages inside the lookup between phase and sample
FIFO_DEPTH, 4, output FIFO entries (power of two, at least ROM_LAT+2)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
enable  in  1  allow new lookups to be issued
cfg_we  in  1  configuration write strobe
cfg_ch  in  CH_W  channel addressed by the configuration write
cfg_fcw  in  ACC_W  FCW to store for cfg_ch
cfg_clr  in  1  with cfg_we: zero the accumulator of cfg_ch
rom_phase  out  PHASE_W  phase to the sine lookup (registered)
rom_y  in  AMP_W  sample from the sine lookup
smp_valid  out  1  output sample available
smp_ready  in  1  consumer accepts the sample
smp_ch  out  CH_W  channel tag of the output sample
smp_data  out  AMP_W  output sample
busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n=0 at a rising edge of clk):
  - clears all acc[c], all fcw[c], the round-robin pointer, the tag pipeline, the FIFO, rom_phase, smp_valid, smp_ch, smp_data and busy.
  - Reset mid-operation discards all in-flight and buffered samples.
- Credit:
  - in_flight counts issued lookups whose samples have not yet been written to the FIFO.
  - Issue condition: enable=1 and fifo_count + in_flight < FIFO_DEPTH.
- Issue edge (issue condition true), for channel p = ptr:
  - rom_phase <= acc[p][ACC_W-1 -: PHASE_W].
  - acc[p] <= acc[p] + fcw[p], wrapping modulo 2^ACC_W.
  - ptr <= (p == NUM_CH-1) ? 0 : p+1.
  - Tag {valid=1, ch=p} enters the tag shift register.
  - With the condition held, one lookup is issued per cycle.
- Tag pipeline and capture:
  - Tags are delayed ROM_LAT+1 edges.
  - At the edge where a valid tag exits, rom_y is written into the FIFO with that tag and in_flight is decremented.
  - Latency from the issue edge to smp_valid=1 is ROM_LAT+2 cycles when the FIFO is empty.
- Output:
  - smp_valid = FIFO not empty; smp_ch and smp_data show the FIFO head.
  - The head pops on smp_valid && smp_ready.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - The FIFO never overflows (guaranteed by credit); a pop on empty is impossible because smp_valid=0.
- Configuration:
  - cfg_we updates fcw[cfg_ch] at the edge. A simultaneous issue on the same channel uses the old fcw.
  - cfg_clr together with cfg_we sets acc[cfg_ch] <= 0; the clear overrides that edge's accumulate.
  - cfg_ch >= NUM_CH is ignored.
- FSM:
  - IDLE: go to RUN when enable=1.
  - RUN: on enable=0, go to DRAIN if in_flight != 0 or the FIFO is not empty, otherwise to IDLE.
  - DRAIN: no issue. Go to RUN if enable=1; go to IDLE when in_flight == 0 and the FIFO is empty.
- Stalls: smp_ready=0 stalls issue once credit is exhausted. The pointer and accumulators freeze, so channel order and phase continuity are preserved.

Decomposition:
- Package sine_dds_pkg holds:
  - CH_W = $clog2(NUM_CH), minimum 1
  - the state enum {IDLE, RUN, DRAIN}
  - the tag struct {valid, ch}
- One sub-module, sine_dds_fifo: synchronous FIFO with parameters depth and width, count output, push/pop, and simultaneous push+pop support.

Test Plan:
- Phase stepping: all test plan scenarios use NUM_CH=4, ACC_W=24, ROM_LAT=1 and the team sine lookup. fcw[1]=0x400000, others 0, smp_ready=1, enable=1 -> ch1 samples 128,255,128,1,128 (repeating); ch0/2/3 constant 128; smp_ch sequence 0,1,2,3,0,...
- Latency: first issue edge to smp_valid=1 -> exactly 3 cycles; thereafter smp_valid continuous at one sample per cycle.
- Backpressure: smp_ready=0 for 20 cycles -> at most 4 samples buffered, busy=1, no loss. Release -> the channel/phase sequence continues with no gap or duplicate.
- Config collision: cfg_we with cfg_clr on ch1 in the same cycle ch1 issues -> the issued phase is the pre-clear value; ch1's next sample = 128 (phase 0).
- Drain/reset: enable dropped with 2 in flight -> state DRAIN, 2 more samples delivered, then IDLE and busy=0. reset_n=0 while samples are buffered -> smp_valid=0 at the next cycle and all accumulators read phase 0 afterwards.
